// File: rtl/calc_pkg.sv
//----------------------------------------------------------------------
// calc_pkg : shared state encoding, parameter defaults, width helper
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

package calc_pkg;

  localparam int c_GAP_DEFAULT     = 1;
  localparam int c_TIMEOUT_DEFAULT = 15;

  typedef logic [2:0] state_t;

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_LOAD_A = 3'd1;
  localparam logic [2:0] c_LOAD_B = 3'd2;
  localparam logic [2:0] c_OP     = 3'd3;
  localparam logic [2:0] c_GAPW   = 3'd4;
  localparam logic [2:0] c_WAIT   = 3'd5;
  localparam logic [2:0] c_DONE   = 3'd6;

  // Bits needed to hold a down-counter preload of max_val (never below 1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/step_timer.sv
//----------------------------------------------------------------------
// step_timer : loadable down-counter with zero flag (gap / wait timing)
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module step_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load wins over decrement; the counter saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/calc_driver.sv
//----------------------------------------------------------------------
// calc_driver : sequences operand/operation pulses into a calculator and
// captures its result. Optional WAIT timeout: CALC_DRIVER_TIMEOUT_EN.
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module calc_driver
  import calc_pkg::*;
#(
  parameter int GAP     = c_GAP_DEFAULT,
  parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  input  logic [1:0] op_steps,
  output logic [3:0] Dados,
  output logic       Instrucao,
  input  logic       fim,
  input  logic [4:0] saida_regC,
  output logic [4:0] result,
  output logic       done,
  output logic       busy,
  output logic       timeout_err,
  output logic [2:0] state
);

  if ((GAP < 1) || (GAP > 7)) begin : g_bad_gap
    $error("calc_driver: GAP out of range 1..7");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("calc_driver: TIMEOUT out of range 1..255");
  end

`ifdef CALC_DRIVER_TIMEOUT_EN
  localparam int c_TMR_MAX = (TIMEOUT > GAP) ? (TIMEOUT - 1) : (GAP - 1);
`else
  localparam int c_TMR_MAX = GAP - 1;
`endif
  localparam int                 c_TMR_W  = cnt_width(c_TMR_MAX);
  localparam logic [c_TMR_W-1:0] c_GAP_LD = c_TMR_W'(GAP - 1);
`ifdef CALC_DRIVER_TIMEOUT_EN
  localparam logic [c_TMR_W-1:0] c_TO_LD  = c_TMR_W'(TIMEOUT - 1);
`endif

  state_t       state_q,  state_d;
  logic [3:0]   dados_q,  dados_d;
  logic         instr_q,  instr_d;
  logic [4:0]   result_q, result_d;
  logic         done_q,   done_d;
  logic         busy_q,   busy_d;
  logic [3:0]   b_q,      b_d;
  logic [1:0]   steps_q,  steps_d;
  logic         bpend_q,  bpend_d;

  logic               tmr_load;
  logic               tmr_dec;
  logic [c_TMR_W-1:0] tmr_val;
  logic               tmr_zero;

`ifdef CALC_DRIVER_TIMEOUT_EN
  logic err_q, err_d;
`endif

  step_timer #(.WIDTH(c_TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Pulse outputs are computed one cycle early so they line up with the state they belong to.
  always_comb begin
    state_d  = state_q;
    dados_d  = dados_q;
    instr_d  = 1'b0;
    result_d = result_q;
    done_d   = 1'b0;
    b_d      = b_q;
    steps_d  = steps_q;
    bpend_d  = bpend_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = c_GAP_LD;
`ifdef CALC_DRIVER_TIMEOUT_EN
    err_d    = err_q;
`endif
    case (state_q)
      c_IDLE: begin
        if (start) begin
          state_d = c_LOAD_A;
          dados_d = op_a;
          instr_d = 1'b1;
          b_d     = op_b;
          steps_d = op_steps;
          bpend_d = 1'b1;
`ifdef CALC_DRIVER_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      c_LOAD_A, c_LOAD_B: begin
        state_d  = c_GAPW;
        tmr_load = 1'b1;
      end
      c_OP: begin
        state_d  = c_GAPW;
        tmr_load = 1'b1;
        steps_d  = steps_q - 2'd1;
      end
      c_GAPW: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (bpend_q) begin
          state_d = c_LOAD_B;
          dados_d = b_q;
          instr_d = 1'b1;
          bpend_d = 1'b0;
        end else if (steps_q != 2'd0) begin
          state_d = c_OP;
          dados_d = 4'd0;
          instr_d = 1'b1;
        end else begin
          state_d = c_WAIT;
`ifdef CALC_DRIVER_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = c_TO_LD;
`endif
        end
      end
      c_WAIT: begin
        if (fim) begin
          state_d  = c_DONE;
          result_d = saida_regC;
          done_d   = 1'b1;
`ifdef CALC_DRIVER_TIMEOUT_EN
        end else if (tmr_zero) begin
          state_d  = c_DONE;
          result_d = 5'd0;
          done_d   = 1'b1;
          err_d    = 1'b1;
        end else begin
          tmr_dec = 1'b1;
`endif
        end
      end
      c_DONE: begin
        state_d = c_IDLE;
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
    busy_d = (state_d != c_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= c_IDLE;
      dados_q  <= 4'd0;
      instr_q  <= 1'b0;
      result_q <= 5'd0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      b_q      <= 4'd0;
      steps_q  <= 2'd0;
      bpend_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dados_q  <= dados_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      b_q      <= b_d;
      steps_q  <= steps_d;
      bpend_q  <= bpend_d;
    end
  end

`ifdef CALC_DRIVER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign state     = state_q;
  assign Dados     = dados_q;
  assign Instrucao = instr_q;
  assign result    = result_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_driver.sv
//----------------------------------------------------------------------
// tb_calc_driver : scoreboard bench; expected pulses/results are queued
// at stimulus time and popped by an independent output monitor.
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module tb_calc_driver;
  import calc_pkg::*;

  localparam int GAP_P = 1;
  localparam int TO_P  = 4;
  localparam int P     = GAP_P + 1;
`ifdef CALC_DRIVER_TIMEOUT_EN
  localparam int MAXDEL = TO_P - 1;
`else
  localparam int MAXDEL = 9;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] op_a, op_b;
  logic [1:0] op_steps;
  logic [3:0] Dados;
  logic       Instrucao;
  logic       fim;
  logic [4:0] saida_regC;
  logic [4:0] result;
  logic       done, busy, timeout_err;
  logic [2:0] state;

  calc_driver #(.GAP(GAP_P), .TIMEOUT(TO_P)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .op_steps(op_steps), .Dados(Dados), .Instrucao(Instrucao), .fim(fim),
    .saida_regC(saida_regC), .result(result), .done(done), .busy(busy),
    .timeout_err(timeout_err), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [3:0] d; } pulse_t;
  typedef struct { int cyc; logic [4:0] r; logic e; } done_t;
  pulse_t pulse_q[$];
  done_t  done_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=present required=absent (cycle %0d)", name, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Output monitor: every pulse and every done must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (Instrucao) begin
        if (pulse_q.size() == 0) fail("unexpected_pulse");
        else begin
          pulse_t pe;
          pe = pulse_q.pop_front();
          chk("pulse_cycle", cyc, pe.cyc);
          chk("pulse_dados", {28'd0, Dados}, {28'd0, pe.d});
        end
      end
      if (done) begin
        if (done_q.size() == 0) fail("unexpected_done");
        else begin
          done_t de;
          de = done_q.pop_front();
          chk("done_cycle", cyc, de.cyc);
          chk("done_result", {27'd0, result}, {27'd0, de.r});
          chk("done_timeout_err", {31'd0, timeout_err}, {31'd0, de.e});
        end
      end
    end
  end

  // One calculation. fdel: WAIT cycles before fim (-1 = never). noise: start+fim in LOAD_A.
  task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                         input int fdel, input logic [4:0] val, input bit noise);
    int c0, n, w, tf, end_cyc;
    logic [4:0] exp_res;
    bit timed_out;
    c0 = cyc;
    n  = 2 + int'(s);
    w  = c0 + 1 + n * P;
    pulse_q.push_back('{c0 + 1, a});
    pulse_q.push_back('{c0 + 1 + P, b});
    for (int k = 0; k < int'(s); k++) pulse_q.push_back('{c0 + 1 + (2 + k) * P, 4'd0});
    timed_out = (fdel < 0);
    if (timed_out) begin
      end_cyc = w + TO_P;
      exp_res = 5'd0;
      tf      = 0;
    end else begin
      tf      = w + fdel;
      end_cyc = tf + 1;
      exp_res = val;
    end
    done_q.push_back('{end_cyc, exp_res, timed_out});
    start = 1'b1; op_a = a; op_b = b; op_steps = s;
    step();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("err_cleared_on_start", {31'd0, timeout_err}, 32'd0);
    op_a = 4'($urandom); op_b = 4'($urandom); op_steps = 2'($urandom);
    while (cyc < w) begin
      start      = (noise && cyc == c0 + 1) ? 1'b1 : 1'($urandom);
      fim        = (noise && cyc == c0 + 1) ? 1'b1 : 1'($urandom);
      saida_regC = 5'($urandom);
      step();
    end
    start = 1'b0;
    fim   = 1'b0;
    chk("wait_state", {29'd0, state}, {29'd0, c_WAIT});
    if (!timed_out) begin
      wait_until(tf);
      fim        = 1'b1;
      saida_regC = val;
      start      = 1'($urandom);
      step();
      fim   = 1'b0;
      start = 1'b0;
    end
    wait_until(end_cyc);
    chk("done_state", {29'd0, state}, {29'd0, c_DONE});
    start = 1'($urandom);
    step();
    start = 1'b0;
    chk("idle_state", {29'd0, state}, {29'd0, c_IDLE});
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("result_hold", {27'd0, result}, {27'd0, exp_res});
    chk("err_sticky", {31'd0, timeout_err}, {31'd0, timed_out});
  endtask

  // Reset asserted while the first OP pulse is on the wire.
  task automatic reset_mid_op();
    int c0;
    c0 = cyc;
    pulse_q.push_back('{c0 + 1, 4'd9});
    pulse_q.push_back('{c0 + 1 + P, 4'd6});
    start = 1'b1; op_a = 4'd9; op_b = 4'd6; op_steps = 2'd3;
    step();
    start = 1'b0;
    wait_until(c0 + 1 + 2 * P);
    chk("op_state_before_rst", {29'd0, state}, {29'd0, c_OP});
    #1;
    rst = 1'b1;
    pulse_q.delete();
    done_q.delete();
    #1;
    chk("rst_instr", {31'd0, Instrucao}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dados", {28'd0, Dados}, 32'd0);
    chk("rst_state", {29'd0, state}, {29'd0, c_IDLE});
    step();
    rst = 1'b0;
    step();
    chk("no_pulse_after_rst", {31'd0, Instrucao}, 32'd0);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    fail("watchdog");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op_a = 4'd0; op_b = 4'd0; op_steps = 2'd0;
    fim = 1'b0; saida_regC = 5'd0;
    step();
    step();
    chk("reset_dados", {28'd0, Dados}, 32'd0);
    chk("reset_instr", {31'd0, Instrucao}, 32'd0);
    chk("reset_result", {27'd0, result}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_err", {31'd0, timeout_err}, 32'd0);
    chk("reset_state", {29'd0, state}, {29'd0, c_IDLE});
    rst = 1'b0;
    step();
    chk("first_cycle_no_pulse", {31'd0, Instrucao}, 32'd0);

    run_txn(4'd3, 4'd5, 2'd0, 2, 5'd8, 1'b0);
    run_txn(4'd7, 4'd2, 2'd3, 1, 5'd17, 1'b0);
    run_txn(4'd12, 4'd1, 2'd1, 0, 5'd4, 1'b1);
    run_txn(4'd15, 4'd15, 2'd2, 1, 5'd31, 1'b0);
    reset_mid_op();
    run_txn(4'd10, 4'd11, 2'd3, 2, 5'd21, 1'b0);
`ifdef CALC_DRIVER_TIMEOUT_EN
    run_txn(4'd1, 4'd2, 2'd1, -1, 5'd0, 1'b0);
    run_txn(4'd2, 4'd3, 2'd0, TO_P - 1, 5'd19, 1'b0);
`endif
    for (int i = 0; i < 40; i++) begin
      int fd;
      fd = $urandom_range(0, MAXDEL);
`ifdef CALC_DRIVER_TIMEOUT_EN
      if ($urandom_range(0, 4) == 0) fd = -1;
`endif
      run_txn(4'($urandom), 4'($urandom), 2'($urandom), fd, 5'($urandom), 1'($urandom));
    end
    step();
    chk("pulse_queue_drained", pulse_q.size(), 32'd0);
    chk("done_queue_drained", done_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
